// File: rtl/rpe_dbuf_if.sv
// rpe_dbuf_if: groups the weight, activation and partial-sum signals of one
// reduced-precision PE cell.
//   master modport: the array-side driver. It drives w_in/w_in_valid/w_swap_in,
//                   a_in/a_in_valid and psum_in, and observes the pass-through
//                   outputs.
//   slave modport : the PE cell. It consumes those inputs and drives w_pass,
//                   w_pass_valid, w_swap_pass, a_pass, a_pass_valid, psum_out,
//                   psum_out_valid and ovf.
interface rpe_dbuf_if #(
  parameter int ACT_W  = 7,
  parameter int WMAG_W = 4,
  parameter int PSUM_W = 20
);
  logic [WMAG_W:0]   w_in;
  logic              w_in_valid;
  logic              w_swap_in;
  logic [ACT_W-1:0]  a_in;
  logic              a_in_valid;
  logic [PSUM_W-1:0] psum_in;

  logic [WMAG_W:0]   w_pass;
  logic              w_pass_valid;
  logic              w_swap_pass;
  logic [ACT_W-1:0]  a_pass;
  logic              a_pass_valid;
  logic [PSUM_W-1:0] psum_out;
  logic              psum_out_valid;
  logic              ovf;

  modport master (
    output w_in, w_in_valid, w_swap_in, a_in, a_in_valid, psum_in,
    input  w_pass, w_pass_valid, w_swap_pass, a_pass, a_pass_valid,
           psum_out, psum_out_valid, ovf
  );

  modport slave (
    input  w_in, w_in_valid, w_swap_in, a_in, a_in_valid, psum_in,
    output w_pass, w_pass_valid, w_swap_pass, a_pass, a_pass_valid,
           psum_out, psum_out_valid, ovf
  );
endinterface

// File: rtl/rpe_dbuf.sv
// rpe_dbuf: weight-stationary systolic PE with a double-buffered weight.
// Activations are odd-coded (A = {a_in,1}); weights are mode-coded
// (MSB = mode, low bits = magnitude m):
//   mode 0: P = A*(2m+1)
//   mode 1: P = A*m*2^WMAG_W
// A shadow weight register loads from w_in while the active register drives
// the multiplier. w_swap_in commits shadow -> active without stalling MACs.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : rpe_dbuf_if.slave (weight/activation/psum in, registered passes out)
module rpe_dbuf #(
  parameter int ACT_W    = 7,
  parameter int WMAG_W   = 4,
  parameter int ROWS     = 8,
  parameter int PSUM_W   = ACT_W + 1 + 2*WMAG_W + $clog2(ROWS) + 1,
  parameter int SATURATE = 0
) (
  input  logic      clk,
  input  logic      rst_n,
  rpe_dbuf_if.slave bus
);

  // Full-precision product width: (ACT_W+1)-bit A times a (2*WMAG_W)-bit
  // effective multiplier covers both weight modes.
  localparam int P_W = ACT_W + 1 + 2*WMAG_W;

  logic [WMAG_W:0]   shadow_q;
  logic [WMAG_W:0]   active_q;

  logic [P_W-1:0]    a_ext;
  logic [P_W-1:0]    m_ext;
  logic [P_W-1:0]    prod;
  logic [PSUM_W:0]   sum;
  logic [PSUM_W-1:0] psum_next;

  // NOTE: every combinational output gets a value on every path, so no
  // latch is inferred.
  always_comb begin
    a_ext = P_W'({bus.a_in, 1'b1});
    m_ext = P_W'(active_q[WMAG_W-1:0]);
    if (active_q[WMAG_W]) begin
      prod = (a_ext * m_ext) << WMAG_W;
    end else begin
      prod = ((a_ext * m_ext) << 1) + a_ext;
    end
    // One extra bit above PSUM_W catches the carry-out for ovf and clamping.
    sum = {1'b0, bus.psum_in} + (PSUM_W+1)'(prod);
    psum_next = sum[PSUM_W-1:0];
    if (SATURATE != 0 && sum[PSUM_W]) begin
      psum_next = '1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every read in
  // this block sees the value from before the edge. That is what lets a swap
  // take the old shadow while a same-cycle load overwrites it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q           <= '0;
      active_q           <= '0;
      bus.w_pass         <= '0;
      bus.w_pass_valid   <= 1'b0;
      bus.w_swap_pass    <= 1'b0;
      bus.a_pass         <= '0;
      bus.a_pass_valid   <= 1'b0;
      bus.psum_out       <= '0;
      bus.psum_out_valid <= 1'b0;
      bus.ovf            <= 1'b0;
    end else begin
      if (bus.w_in_valid) begin
        shadow_q   <= bus.w_in;
        bus.w_pass <= bus.w_in;
      end
      bus.w_pass_valid <= bus.w_in_valid;
      bus.w_swap_pass  <= bus.w_swap_in;

      if (bus.w_swap_in) begin
        active_q <= shadow_q;
      end

      bus.a_pass_valid   <= bus.a_in_valid;
      bus.psum_out_valid <= bus.a_in_valid;
      if (bus.a_in_valid) begin
        bus.a_pass   <= bus.a_in;
        bus.psum_out <= psum_next;
      end else begin
        bus.psum_out <= '0;
      end

      // A swap starts a new tile and clears the flag. An overflow from the
      // MAC in the same cycle still sets it, because that result was real.
      bus.ovf <= (bus.ovf & ~bus.w_swap_in) | (bus.a_in_valid & sum[PSUM_W]);
    end
  end

endmodule
